// File: rtl/ripple_mon_pkg.sv
// Shared state encodings and default widths for the ripple counter monitor.
package ripple_mon_pkg;

  localparam int DEF_CNT_W  = 4;
  localparam int DEF_WRAP_W = 8;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

endpackage

// File: rtl/ripple_count_monitor_stable_filter.sv
// Two-flop sync plus run-length check; accept pulses on the edge s2 has held a value STABLE_N edges.
// Latency: input stable -> accept 2+STABLE_N-1 edges; no backpressure, accept repeats while steady.
module stable_filter
  import ripple_mon_pkg::*;
#(
  parameter int W        = DEF_CNT_W,
  parameter int STABLE_N = 2
) (
  input  logic         CLOCK,
  input  logic         CLEAR,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         accept
);

  localparam int RUN_W = $clog2(STABLE_N + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_N);

  logic [W-1:0]     s1_q, s1_d;
  logic [W-1:0]     s2_q, s2_d;
  logic [RUN_W-1:0] run_q, run_d;

  // run counts consecutive edges s2 has loaded the same value, saturating at STABLE_N
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
    if (s1_q != s2_q) begin
      run_d = RUN_W'(1);
    end else if (run_q != RUN_MAX) begin
      run_d = run_q + 1'b1;
    end else begin
      run_d = run_q;
    end
    accept = (run_d == RUN_MAX);
    q      = s2_d;
  end

  always_ff @(posedge CLOCK) begin
    if (CLEAR) begin
      s1_q  <= '0;
      s2_q  <= '0;
      run_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/ripple_count_monitor.sv
// Extends a filtered 4-bit ripple count with a wrap counter and flags illegal steps.
// Latency: stable Q_IN reaches EXT_COUNT 2+STABLE_N-1 edges later; no backpressure.
module ripple_count_monitor
  import ripple_mon_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int WRAP_W   = DEF_WRAP_W,
  parameter int STABLE_N = 2
) (
  input  logic                    CLOCK,
  input  logic                    CLEAR,
  input  logic [CNT_W-1:0]        Q_IN,
  input  logic                    ERR_CLR,
  output logic [WRAP_W+CNT_W-1:0] EXT_COUNT,
  output logic                    VALID,
  output logic                    WRAP_PULSE,
  output logic                    STEP_ERR
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  acc_val;
  logic              acc;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  lo_q, lo_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              valid_q, valid_d;
  logic              pulse_q, pulse_d;
  logic              err_q, err_d;

  stable_filter #(
    .W        (CNT_W),
    .STABLE_N (STABLE_N)
  ) u_filter (
    .CLOCK  (CLOCK),
    .CLEAR  (CLEAR),
    .d      (Q_IN),
    .q      (acc_val),
    .accept (acc)
  );

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    wrap_d  = wrap_q;
    valid_d = valid_q;
    pulse_d = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_INIT: begin
        if (acc) begin
          lo_d    = acc_val;
          wrap_d  = '0;
          valid_d = 1'b1;
          state_d = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (acc && (acc_val != lo_q)) begin
          if ((lo_q == CNT_MAX) && (acc_val == '0)) begin
            wrap_d  = wrap_q + 1'b1;
            lo_d    = '0;
            pulse_d = 1'b1;
          end else if ((lo_q != CNT_MAX) && (acc_val == lo_q + 1'b1)) begin
            lo_d = acc_val;
          end else if (acc_val == '0) begin
            // upstream counter was cleared: restart the extended count
            lo_d   = '0;
            wrap_d = '0;
          end else begin
            err_d   = 1'b1;
            valid_d = 1'b0;
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        if (ERR_CLR) begin
          err_d   = 1'b0;
          state_d = ST_INIT;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (CLEAR) begin
      state_q <= ST_INIT;
      lo_q    <= '0;
      wrap_q  <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      wrap_q  <= wrap_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

  assign EXT_COUNT  = {wrap_q, lo_q};
  assign VALID      = valid_q;
  assign WRAP_PULSE = pulse_q;
  assign STEP_ERR   = err_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Bench for ripple_count_monitor: directed scenarios plus random stimulus against a behavioural model.
module tb_ripple_count_monitor;

  localparam int STABLE_N = 2;

  logic        CLOCK = 1'b0;
  logic        CLEAR;
  logic        ERR_CLR;
  logic [3:0]  Q_IN;
  logic [11:0] EXT_COUNT;
  logic        VALID;
  logic        WRAP_PULSE;
  logic        STEP_ERR;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state (0 = init, 1 = track, 2 = error)
  int m_state;
  int m_lo;
  int m_wrap;
  bit m_valid;
  bit m_pulse;
  bit m_err;
  int m_prev;
  int m_hist[$];

  ripple_count_monitor #(
    .CNT_W    (4),
    .WRAP_W   (8),
    .STABLE_N (STABLE_N)
  ) dut (
    .CLOCK      (CLOCK),
    .CLEAR      (CLEAR),
    .Q_IN       (Q_IN),
    .ERR_CLR    (ERR_CLR),
    .EXT_COUNT  (EXT_COUNT),
    .VALID      (VALID),
    .WRAP_PULSE (WRAP_PULSE),
    .STEP_ERR   (STEP_ERR)
  );

  always #5 CLOCK = ~CLOCK;

  // One clock edge; the model applies the spec rules to the inputs seen at that edge.
  task automatic tick();
    int nv;
    bit acc;
    @(posedge CLOCK);
    if (CLEAR) begin
      m_state = 0; m_lo = 0; m_wrap = 0;
      m_valid = 0; m_pulse = 0; m_err = 0;
      m_prev = 0;
      m_hist.delete();
    end else begin
      nv = m_prev;
      m_prev = int'(Q_IN);
      m_hist.push_back(nv);
      if (m_hist.size() > 8) void'(m_hist.pop_front());
      acc = (m_hist.size() >= STABLE_N);
      for (int i = 0; i < STABLE_N; i++)
        if (acc && m_hist[m_hist.size()-1-i] != nv) acc = 0;
      m_pulse = 0;
      case (m_state)
        0: if (acc) begin
          m_lo = nv; m_wrap = 0; m_valid = 1; m_state = 1;
        end
        1: if (acc && nv != m_lo) begin
          if (m_lo == 15 && nv == 0) begin
            m_wrap = (m_wrap + 1) % 256; m_lo = 0; m_pulse = 1;
          end else if (nv == m_lo + 1) begin
            m_lo = nv;
          end else if (nv == 0) begin
            m_lo = 0; m_wrap = 0;
          end else begin
            m_err = 1; m_valid = 0; m_state = 2;
          end
        end
        default: if (ERR_CLR) begin
          m_err = 0; m_state = 0;
        end
      endcase
    end
    #1;
  endtask

  task automatic drive(input int v, input int n);
    Q_IN = 4'(v);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
  endtask

  task automatic test_reset();
    CLEAR = 1'b1; ERR_CLR = 1'b0; Q_IN = 4'h9;
    repeat (3) tick();
    n_checks++; if (EXT_COUNT !== 12'h000) begin n_fail++; $display("FAIL reset_ext: got %h expected 000", EXT_COUNT); end
    n_checks++; if (VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", VALID); end
    n_checks++; if (WRAP_PULSE !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b expected 0", WRAP_PULSE); end
    n_checks++; if (STEP_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", STEP_ERR); end
    CLEAR = 1'b0;
  endtask

  task automatic test_count_wrap();
    int pulses = 0;
    do_reset();
    for (int k = 0; k < 18; k++) begin
      Q_IN = 4'(k % 16);
      for (int c = 0; c < 4; c++) begin
        tick();
        if (WRAP_PULSE === 1'b1) pulses++;
        if (k == 0 && c == 0) begin
          n_checks++; if (VALID !== 1'b0) begin n_fail++; $display("FAIL count_valid_early: got %b expected 0", VALID); end
        end
      end
      n_checks++; if (EXT_COUNT !== 12'(k)) begin n_fail++; $display("FAIL count_ext k=%0d: got %h expected %h", k, EXT_COUNT, 12'(k)); end
      n_checks++; if (VALID !== 1'b1) begin n_fail++; $display("FAIL count_valid k=%0d: got %b expected 1", k, VALID); end
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL count_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int v = 0; v < 8; v++) drive(v, 3);
    drive(7, 1);
    n_checks++; if (EXT_COUNT[3:0] !== 4'h7) begin n_fail++; $display("FAIL glitch_pre: got %h expected 7", EXT_COUNT[3:0]); end
    Q_IN = 4'h5; tick();
    Q_IN = 4'h8; tick();
    n_checks++; if (EXT_COUNT[3:0] !== 4'h7) begin n_fail++; $display("FAIL glitch_hold1: got %h expected 7", EXT_COUNT[3:0]); end
    tick();
    n_checks++; if (EXT_COUNT[3:0] !== 4'h7) begin n_fail++; $display("FAIL glitch_hold2: got %h expected 7", EXT_COUNT[3:0]); end
    tick();
    n_checks++; if (EXT_COUNT[3:0] !== 4'h8) begin n_fail++; $display("FAIL glitch_post: got %h expected 8", EXT_COUNT[3:0]); end
    n_checks++; if (STEP_ERR !== 1'b0) begin n_fail++; $display("FAIL glitch_err: got %b expected 0", STEP_ERR); end
  endtask

  task automatic test_step_err();
    do_reset();
    for (int v = 0; v < 4; v++) drive(v, 3);
    drive(3, 1);
    ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
    n_checks++; if (EXT_COUNT !== 12'h003 || VALID !== 1'b1 || STEP_ERR !== 1'b0) begin
      n_fail++; $display("FAIL errclr_in_track: got ext=%h valid=%b err=%b expected 003/1/0", EXT_COUNT, VALID, STEP_ERR);
    end
    drive(9, 4);
    n_checks++; if (STEP_ERR !== 1'b1) begin n_fail++; $display("FAIL step_err_set: got %b expected 1", STEP_ERR); end
    n_checks++; if (VALID !== 1'b0) begin n_fail++; $display("FAIL step_valid: got %b expected 0", VALID); end
    n_checks++; if (EXT_COUNT !== 12'h003) begin n_fail++; $display("FAIL step_ext_hold: got %h expected 003", EXT_COUNT); end
    ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
    n_checks++; if (STEP_ERR !== 1'b0) begin n_fail++; $display("FAIL step_err_clr: got %b expected 0", STEP_ERR); end
    repeat (2) tick();
    n_checks++; if (EXT_COUNT !== 12'h009) begin n_fail++; $display("FAIL step_reacq_ext: got %h expected 009", EXT_COUNT); end
    n_checks++; if (VALID !== 1'b1) begin n_fail++; $display("FAIL step_reacq_valid: got %b expected 1", VALID); end
  endtask

  task automatic test_ext_clear();
    int pulses = 0;
    do_reset();
    for (int lap = 0; lap < 2; lap++)
      for (int v = 0; v < 16; v++) drive(v, 3);
    for (int v = 0; v < 6; v++) drive(v, 3);
    n_checks++; if (EXT_COUNT !== 12'h025) begin n_fail++; $display("FAIL clr_pre: got %h expected 025", EXT_COUNT); end
    Q_IN = 4'h0;
    repeat (4) begin
      tick();
      if (WRAP_PULSE === 1'b1) pulses++;
    end
    n_checks++; if (EXT_COUNT !== 12'h000) begin n_fail++; $display("FAIL clr_ext: got %h expected 000", EXT_COUNT); end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL clr_pulse: got %0d expected 0", pulses); end
    n_checks++; if (STEP_ERR !== 1'b0) begin n_fail++; $display("FAIL clr_err: got %b expected 0", STEP_ERR); end
  endtask

  task automatic test_back_to_back();
    drive(5, 4);
    n_checks++; if (STEP_ERR !== 1'b1) begin n_fail++; $display("FAIL b2b_err_set: got %b expected 1", STEP_ERR); end
    CLEAR = 1'b1; ERR_CLR = 1'b1; tick();
    CLEAR = 1'b0; ERR_CLR = 1'b0;
    n_checks++; if (EXT_COUNT !== 12'h000 || VALID !== 1'b0 || WRAP_PULSE !== 1'b0 || STEP_ERR !== 1'b0) begin
      n_fail++; $display("FAIL b2b_reset: got ext=%h valid=%b pulse=%b err=%b expected 000/0/0/0", EXT_COUNT, VALID, WRAP_PULSE, STEP_ERR);
    end
    for (int lap = 0; lap < 256; lap++)
      for (int v = 0; v < 16; v++) drive(v, 3);
    n_checks++; if (EXT_COUNT !== 12'hFFF) begin n_fail++; $display("FAIL wrap255: got %h expected fff", EXT_COUNT); end
    Q_IN = 4'h0;
    repeat (3) tick();
    n_checks++; if (WRAP_PULSE !== 1'b1) begin n_fail++; $display("FAIL wrap_ovf_pulse: got %b expected 1", WRAP_PULSE); end
    n_checks++; if (EXT_COUNT !== 12'h000) begin n_fail++; $display("FAIL wrap_ovf_ext: got %h expected 000", EXT_COUNT); end
    tick();
    n_checks++; if (WRAP_PULSE !== 1'b0) begin n_fail++; $display("FAIL wrap_pulse_width: got %b expected 0", WRAP_PULSE); end
    n_checks++; if (STEP_ERR !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf_err: got %b expected 0", STEP_ERR); end
  endtask

  task automatic test_random();
    int cur = 0;
    int nv;
    int hold;
    int r;
    int cyc = 0;
    do_reset();
    while (cyc < 2500) begin
      r = $urandom_range(0, 99);
      if (r < 60)      nv = (cur + 1) % 16;
      else if (r < 70) nv = 0;
      else if (r < 85) nv = $urandom_range(0, 15);
      else             nv = cur;
      cur = nv;
      hold = $urandom_range(1, 5);
      Q_IN = 4'(nv);
      for (int h = 0; h < hold; h++) begin
        ERR_CLR = ($urandom_range(0, 9) == 0);
        CLEAR   = ($urandom_range(0, 99) == 0);
        tick();
        cyc++;
        n_checks++; if (EXT_COUNT !== 12'(m_wrap * 16 + m_lo)) begin n_fail++; $display("FAIL rnd_ext cyc=%0d: got %h expected %h", cyc, EXT_COUNT, 12'(m_wrap * 16 + m_lo)); end
        n_checks++; if (VALID !== m_valid) begin n_fail++; $display("FAIL rnd_valid cyc=%0d: got %b expected %b", cyc, VALID, m_valid); end
        n_checks++; if (WRAP_PULSE !== m_pulse) begin n_fail++; $display("FAIL rnd_pulse cyc=%0d: got %b expected %b", cyc, WRAP_PULSE, m_pulse); end
        n_checks++; if (STEP_ERR !== m_err) begin n_fail++; $display("FAIL rnd_err cyc=%0d: got %b expected %b", cyc, STEP_ERR, m_err); end
      end
    end
    CLEAR = 1'b0; ERR_CLR = 1'b0;
  endtask

  initial begin
    CLEAR = 1'b1; ERR_CLR = 1'b0; Q_IN = 4'h0;
    test_reset();
    test_count_wrap();
    test_glitch();
    test_step_err();
    test_ext_clear();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
